// File: rtl/pingpong_responder_if.sv
// Signal bundle between the HPS PIO side (master) and the ping-pong responder (slave).
// Toggle handshake: each level change on ping_in is one request; pong_out changing to match it is the answer.
interface pingpong_responder_if #(
   parameter int DELAY_W = 16,
   parameter int CNT_W   = 16
);
   logic               ping_in;
   logic               enable;
   logic [DELAY_W-1:0] delay_cycles;
   logic               clear_err;
   logic               pong_out;
   logic               busy;
   logic [CNT_W-1:0]   ping_count;
   logic               overrun;
   logic               link_alive;
   logic [1:0]         dbg_state;

   modport master (
      output ping_in, enable, delay_cycles, clear_err,
      input  pong_out, busy, ping_count, overrun, link_alive, dbg_state
   );

   modport slave (
      input  ping_in, enable, delay_cycles, clear_err,
      output pong_out, busy, ping_count, overrun, link_alive, dbg_state
   );
endinterface

// File: rtl/pingpong_responder.sv
// FPGA end of the HPS ping-pong link: answers each ping_in toggle with a delayed
// pong_out toggle, counts answers, flags overlapping pings and tracks liveness.
module pingpong_responder #(
   parameter int DELAY_W = 16,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 50000000
) (
   input logic                clk,
   input logic                reset,
   pingpong_responder_if.slave bus
);

   localparam int ICNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [ICNT_W-1:0] ICNT_MAX = ICNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_RESPOND = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               s1_q, s1_d;
   logic               s2_q, s2_d;
   logic               s3_q, s3_d;
   logic [DELAY_W-1:0] dcnt_q, dcnt_d;
   logic               pong_q, pong_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovr_q, ovr_d;
   logic               alive_q, alive_d;
   logic [ICNT_W-1:0]  icnt_q, icnt_d;
   logic               ping_edge;

   always_comb begin
      s1_d      = bus.ping_in;
      s2_d      = s1_q;
      s3_d      = s2_q;
      ping_edge = s2_q ^ s3_q;

      state_d = state_q;
      dcnt_d  = dcnt_q;
      pong_d  = pong_q;
      cnt_d   = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (ping_edge && bus.enable) begin
               dcnt_d  = bus.delay_cycles;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (dcnt_q == '0) state_d = ST_RESPOND;
            else              dcnt_d  = dcnt_q - 1'b1;
         end
         ST_RESPOND: begin
            // Answer with the level present now, so a double toggle nets no change.
            pong_d  = s2_q;
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      ovr_d = ovr_q;
      if (bus.clear_err)                      ovr_d = 1'b0;
      if (ping_edge && (state_q != ST_IDLE))  ovr_d = 1'b1;

      alive_d = alive_q;
      icnt_d  = icnt_q;
      if (ping_edge) begin
         icnt_d  = '0;
         alive_d = 1'b1;
      end else if (icnt_q == ICNT_MAX) begin
         alive_d = 1'b0;
      end else begin
         icnt_d = icnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
         state_q <= ST_IDLE;
         dcnt_q  <= '0;
         pong_q  <= 1'b0;
         cnt_q   <= '0;
         ovr_q   <= 1'b0;
         alive_q <= 1'b0;
         icnt_q  <= '0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         s3_q    <= s3_d;
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         pong_q  <= pong_d;
         cnt_q   <= cnt_d;
         ovr_q   <= ovr_d;
         alive_q <= alive_d;
         icnt_q  <= icnt_d;
      end
   end

   assign bus.pong_out   = pong_q;
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.ping_count = cnt_q;
   assign bus.overrun    = ovr_q;
   assign bus.link_alive = alive_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_pingpong_responder.sv
// Directed bench for pingpong_responder with TIMEOUT = 8 and CNT_W = 4.
module tb_pingpong_responder;

   localparam int DELAY_W = 16;
   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 8;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   pingpong_responder_if #(.DELAY_W(DELAY_W), .CNT_W(CNT_W)) bus ();

   pingpong_responder #(
      .DELAY_W(DELAY_W),
      .CNT_W  (CNT_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset            = 1'b1;
      bus.ping_in      = 1'b0;
      bus.enable       = 1'b1;
      bus.delay_cycles = '0;
      bus.clear_err    = 1'b0;
      tick(2);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      errors = 0;
      checks = 0;

      // Reset state
      do_reset();
      check("rst_pong",  {31'b0, bus.pong_out},   32'd0);
      check("rst_busy",  {31'b0, bus.busy},       32'd0);
      check("rst_cnt",   {28'b0, bus.ping_count}, 32'd0);
      check("rst_ovr",   {31'b0, bus.overrun},    32'd0);
      check("rst_alive", {31'b0, bus.link_alive}, 32'd0);
      tick(2);

      // Basic ping, delay 0: pong at edge 4
      bus.ping_in = 1'b1;
      tick(2);
      check("b0_busy_e1", {31'b0, bus.busy}, 32'd0);
      tick(1);
      check("b0_busy_e2", {31'b0, bus.busy}, 32'd1);
      tick(1);
      check("b0_pong_e3", {31'b0, bus.pong_out}, 32'd0);
      check("b0_busy_e3", {31'b0, bus.busy}, 32'd1);
      tick(1);
      check("b0_pong_e4", {31'b0, bus.pong_out},   32'd1);
      check("b0_busy_e4", {31'b0, bus.busy},       32'd0);
      check("b0_cnt",     {28'b0, bus.ping_count}, 32'd1);
      check("b0_ovr",     {31'b0, bus.overrun},    32'd0);

      // Delay 10, both edges: pong at edge 14
      do_reset();
      bus.delay_cycles = 16'd10;
      tick(1);
      bus.ping_in = 1'b1;
      tick(14);
      check("d10_r_e13", {31'b0, bus.pong_out}, 32'd0);
      tick(1);
      check("d10_r_e14", {31'b0, bus.pong_out}, 32'd1);
      tick(2);
      bus.ping_in = 1'b0;
      tick(14);
      check("d10_f_e13", {31'b0, bus.pong_out}, 32'd1);
      tick(1);
      check("d10_f_e14", {31'b0, bus.pong_out},   32'd0);
      check("d10_cnt",   {28'b0, bus.ping_count}, 32'd2);

      // Overrun: two toggles during WAIT
      do_reset();
      bus.delay_cycles = 16'd20;
      tick(1);
      bus.ping_in = 1'b1;
      tick(4);
      bus.ping_in = 1'b0;
      tick(3);
      check("ovr_set", {31'b0, bus.overrun}, 32'd1);
      tick(30);
      check("ovr_pong", {31'b0, bus.pong_out},   32'd0);
      check("ovr_cnt",  {28'b0, bus.ping_count}, 32'd1);
      check("ovr_busy", {31'b0, bus.busy},       32'd0);
      bus.clear_err = 1'b1;
      tick(1);
      bus.clear_err = 1'b0;
      check("ovr_clr", {31'b0, bus.overrun}, 32'd0);
      // Same-cycle clear and new overrun event
      bus.ping_in = 1'b1;
      tick(3);
      check("ovr2_wait", {31'b0, bus.busy}, 32'd1);
      bus.ping_in = 1'b0;
      tick(2);
      bus.clear_err = 1'b1;
      tick(1);
      bus.clear_err = 1'b0;
      check("ovr_setwins", {31'b0, bus.overrun}, 32'd1);
      tick(30);
      check("ovr2_cnt", {28'b0, bus.ping_count}, 32'd2);

      // Enable gating
      do_reset();
      bus.enable = 1'b0;
      tick(1);
      bus.ping_in = 1'b1;
      tick(6);
      check("en0_pong",  {31'b0, bus.pong_out},   32'd0);
      check("en0_cnt",   {28'b0, bus.ping_count}, 32'd0);
      check("en0_busy",  {31'b0, bus.busy},       32'd0);
      check("en0_alive", {31'b0, bus.link_alive}, 32'd1);
      check("en0_ovr",   {31'b0, bus.overrun},    32'd0);
      bus.ping_in = 1'b0;
      tick(4);
      bus.enable  = 1'b1;
      bus.ping_in = 1'b1;
      tick(4);
      check("en1_pong_e3", {31'b0, bus.pong_out}, 32'd0);
      tick(1);
      check("en1_pong_e4", {31'b0, bus.pong_out},   32'd1);
      check("en1_cnt",     {28'b0, bus.ping_count}, 32'd1);

      // Liveness with TIMEOUT = 8
      do_reset();
      tick(1);
      bus.ping_in = 1'b1;
      tick(2);
      check("live_e1", {31'b0, bus.link_alive}, 32'd0);
      tick(1);
      check("live_e2", {31'b0, bus.link_alive}, 32'd1);
      tick(7);
      check("live_e9", {31'b0, bus.link_alive}, 32'd1);
      tick(1);
      check("live_e10", {31'b0, bus.link_alive}, 32'd0);
      tick(3);
      check("live_hold", {31'b0, bus.link_alive}, 32'd0);
      bus.ping_in = 1'b0;
      tick(2);
      check("live2_e1", {31'b0, bus.link_alive}, 32'd0);
      tick(1);
      check("live2_e2", {31'b0, bus.link_alive}, 32'd1);

      // Reset mid-WAIT with ping_in held high, then resync response
      do_reset();
      bus.delay_cycles = 16'd5;
      tick(1);
      bus.ping_in = 1'b1;
      tick(4);
      check("mid_busy", {31'b0, bus.busy}, 32'd1);
      reset = 1'b1;
      tick(1);
      check("mid_rst_pong",  {31'b0, bus.pong_out},   32'd0);
      check("mid_rst_busy",  {31'b0, bus.busy},       32'd0);
      check("mid_rst_cnt",   {28'b0, bus.ping_count}, 32'd0);
      check("mid_rst_alive", {31'b0, bus.link_alive}, 32'd0);
      reset = 1'b0;
      tick(9);
      check("mid_resync_e8", {31'b0, bus.pong_out}, 32'd0);
      tick(1);
      check("mid_resync_e9", {31'b0, bus.pong_out},   32'd1);
      check("mid_resync_cnt", {28'b0, bus.ping_count}, 32'd1);

      // Counter wrap at CNT_W = 4
      do_reset();
      for (int i = 0; i < 17; i++) begin
         bus.ping_in = ~bus.ping_in;
         tick(6);
         if (i == 14) check("wrap_15", {28'b0, bus.ping_count}, 32'd15);
         if (i == 15) check("wrap_16", {28'b0, bus.ping_count}, 32'd0);
      end
      check("wrap_17",  {28'b0, bus.ping_count}, 32'd1);
      check("wrap_ovr", {31'b0, bus.overrun},    32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
